// File: rtl/game_ctrl_pkg.sv
// Shared types and helpers for the board-game turn controller.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StTurn  = 2'b01,
    StCheck = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Index of the player after idx, wrapping at n.
  function automatic int unsigned next_player(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Move-entry / board-check signal bundle around the turn controller.
interface turn_controller_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned MAX_TURNS   = 9
);
  localparam int unsigned PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned TW = $clog2(MAX_TURNS + 1);

  logic                   start;
  logic                   abort;
  logic                   player_move;
  logic                   cpu_move;
  logic                   illegal_move;
  logic                   win;
  logic                   no_space;
  logic [NUM_PLAYERS-1:0] play_en;
  logic [PW-1:0]          active_player;
  logic [TW-1:0]          turn_count;
  logic                   game_done;
  logic                   winner_valid;
  logic [PW-1:0]          winner_id;
  logic                   timeout;
  logic                   forfeit;

  // Game-side blocks: move entry, AI and board logic.
  modport master (
    output start, abort, player_move, cpu_move, illegal_move, win, no_space,
    input  play_en, active_player, turn_count, game_done, winner_valid, winner_id,
           timeout, forfeit
  );

  // The turn controller itself.
  modport slave (
    input  start, abort, player_move, cpu_move, illegal_move, win, no_space,
    output play_en, active_player, turn_count, game_done, winner_valid, winner_id,
           timeout, forfeit
  );
endinterface

// File: rtl/turn_timer.sv
// Per-turn down-counter: load arms a fresh turn, expire_o flags the last cycle.
module turn_timer #(
  parameter int unsigned Cycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned CW = (Cycles > 1) ? $clog2(Cycles) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear beats load beats count; the counter parks at zero once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CW'(Cycles - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/turn_controller.sv
// Game-turn sequencer: grants moves, runs the check cycle, handles forfeit and abort.
module turn_controller
  import game_ctrl_pkg::*;
#(
  parameter int unsigned            NUM_PLAYERS    = 2,
  parameter logic [NUM_PLAYERS-1:0] CPU_MASK       = 2'b10,
  parameter int unsigned            TIMEOUT_CYCLES = 0,
  parameter int unsigned            MAX_ILLEGAL    = 3,
  parameter int unsigned            MAX_TURNS      = 9
) (
  input logic              clock,
  input logic              reset,
  turn_controller_if.slave bus
);
  localparam int unsigned PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned TW = $clog2(MAX_TURNS + 1);
  localparam int unsigned IW = $clog2(MAX_ILLEGAL + 1);

  state_e                 state_q, state_d;
  logic [PW-1:0]          active_q, active_d;
  logic [NUM_PLAYERS-1:0] play_en_q, play_en_d;
  logic [TW-1:0]          turn_cnt_q, turn_cnt_d;
  logic [IW-1:0]          illegal_q, illegal_d;
  logic                   game_done_q, game_done_d;
  logic                   winner_valid_q, winner_valid_d;
  logic [PW-1:0]          winner_id_q, winner_id_d;
  logic                   timeout_q, timeout_d;
  logic                   forfeit_q, forfeit_d;

  logic          valid_strobe, expire, skip, begin_game;
  logic          tmr_load, tmr_clear, tmr_en;
  logic [PW-1:0] next_idx;

  function automatic logic [NUM_PLAYERS-1:0] grant_of(logic [PW-1:0] idx);
    logic [NUM_PLAYERS-1:0] g;
    g      = '0;
    g[idx] = 1'b1;
    return g;
  endfunction

  // Only the strobe kind matching the active player's driver counts.
  assign valid_strobe = CPU_MASK[active_q] ? bus.cpu_move : bus.player_move;
  assign next_idx     = PW'(next_player(32'(active_q), NUM_PLAYERS));

  if (TIMEOUT_CYCLES > 0) begin : g_timer
    turn_timer #(
      .Cycles(TIMEOUT_CYCLES)
    ) u_timer (
      .clk_i   (clock),
      .rst_ni  (reset),
      .load_i  (tmr_load),
      .clear_i (tmr_clear),
      .en_i    (tmr_en),
      .expire_o(expire)
    );
  end else begin : g_no_timer
    logic unused_tmr;
    assign unused_tmr = ^{tmr_load, tmr_clear, tmr_en};
    assign expire     = 1'b0;
  end

  // Next state and registered outputs; abort overrides everything but reset.
  always_comb begin
    state_d        = state_q;
    active_d       = active_q;
    play_en_d      = play_en_q;
    turn_cnt_d     = turn_cnt_q;
    illegal_d      = illegal_q;
    game_done_d    = game_done_q;
    winner_valid_d = winner_valid_q;
    winner_id_d    = winner_id_q;
    timeout_d      = 1'b0;
    forfeit_d      = 1'b0;
    skip           = 1'b0;
    begin_game     = 1'b0;

    case (state_q)
      StIdle: begin
        play_en_d = '0;
        if (bus.start) begin_game = 1'b1;
      end
      StTurn: begin
        if (valid_strobe && !bus.illegal_move) begin
          state_d   = StCheck;
          play_en_d = '0;
          illegal_d = '0;
        end else if (valid_strobe) begin
          if (illegal_q == IW'(MAX_ILLEGAL - 1)) begin
            skip      = 1'b1;
            forfeit_d = 1'b1;
          end else begin
            illegal_d = illegal_q + 1'b1;
          end
        end else if (expire) begin
          skip      = 1'b1;
          timeout_d = 1'b1;
          forfeit_d = 1'b1;
        end
      end
      StCheck: begin
        if (turn_cnt_q != '1) turn_cnt_d = turn_cnt_q + 1'b1;
        if (bus.win) begin
          state_d        = StDone;
          game_done_d    = 1'b1;
          winner_valid_d = 1'b1;
          winner_id_d    = active_q;
        end else if (bus.no_space) begin
          state_d        = StDone;
          game_done_d    = 1'b1;
          winner_valid_d = 1'b0;
        end else begin
          state_d   = StTurn;
          active_d  = next_idx;
          play_en_d = grant_of(next_idx);
        end
      end
      StDone: begin
        play_en_d   = '0;
        game_done_d = 1'b1;
        if (bus.start) begin_game = 1'b1;
      end
      default: begin
        state_d   = StIdle;
        play_en_d = '0;
      end
    endcase

    if (skip) begin
      active_d  = next_idx;
      play_en_d = grant_of(next_idx);
      illegal_d = '0;
    end

    if (begin_game) begin
      state_d        = StTurn;
      active_d       = '0;
      play_en_d      = grant_of('0);
      turn_cnt_d     = '0;
      illegal_d      = '0;
      game_done_d    = 1'b0;
      winner_valid_d = 1'b0;
      winner_id_d    = '0;
    end

    if (bus.abort) begin
      state_d        = StIdle;
      play_en_d      = '0;
      turn_cnt_d     = '0;
      illegal_d      = '0;
      game_done_d    = 1'b0;
      winner_valid_d = 1'b0;
      winner_id_d    = '0;
      timeout_d      = 1'b0;
      forfeit_d      = 1'b0;
    end

    // Timer re-arms on every fresh grant and only counts strobe-free TURN cycles.
    tmr_clear = (state_d != StTurn);
    tmr_load  = (state_q != StTurn) || skip;
    tmr_en    = (state_q == StTurn) && !valid_strobe;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= StIdle;
      active_q       <= '0;
      play_en_q      <= '0;
      turn_cnt_q     <= '0;
      illegal_q      <= '0;
      game_done_q    <= 1'b0;
      winner_valid_q <= 1'b0;
      winner_id_q    <= '0;
      timeout_q      <= 1'b0;
      forfeit_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      active_q       <= active_d;
      play_en_q      <= play_en_d;
      turn_cnt_q     <= turn_cnt_d;
      illegal_q      <= illegal_d;
      game_done_q    <= game_done_d;
      winner_valid_q <= winner_valid_d;
      winner_id_q    <= winner_id_d;
      timeout_q      <= timeout_d;
      forfeit_q      <= forfeit_d;
    end
  end

  assign bus.play_en       = play_en_q;
  assign bus.active_player = active_q;
  assign bus.turn_count    = turn_cnt_q;
  assign bus.game_done     = game_done_q;
  assign bus.winner_valid  = winner_valid_q;
  assign bus.winner_id     = winner_id_q;
  assign bus.timeout       = timeout_q;
  assign bus.forfeit       = forfeit_q;
endmodule

// File: tb/tb_turn_controller.sv
// Directed bench: two-player human/CPU game without timeout, three-player game with timeout.
module tb_turn_controller;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  turn_controller_if #(.NUM_PLAYERS(2), .MAX_TURNS(9)) if_a ();
  turn_controller_if #(.NUM_PLAYERS(3), .MAX_TURNS(9)) if_b ();

  turn_controller #(
    .NUM_PLAYERS   (2),
    .CPU_MASK      (2'b10),
    .TIMEOUT_CYCLES(0),
    .MAX_ILLEGAL   (3),
    .MAX_TURNS     (9)
  ) u_dut_a (
    .clock(clk),
    .reset(rst_n),
    .bus  (if_a)
  );

  turn_controller #(
    .NUM_PLAYERS   (3),
    .CPU_MASK      (3'b000),
    .TIMEOUT_CYCLES(4),
    .MAX_ILLEGAL   (3),
    .MAX_TURNS     (9)
  ) u_dut_b (
    .clock(clk),
    .reset(rst_n),
    .bus  (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst_n = 1'b0;
    tick();
    tick();
    got = {if_a.play_en, if_a.active_player, if_a.turn_count, if_a.game_done,
           if_a.winner_valid, if_a.winner_id, if_a.timeout, if_a.forfeit};
    checks++;
    if (got !== 16'h0) begin
      failures++;
      $display("FAIL reset_a got=%h exp=%h", got, 16'h0);
    end
    got = {if_b.play_en, if_b.active_player, if_b.turn_count, if_b.game_done,
           if_b.winner_valid, if_b.winner_id, if_b.timeout, if_b.forfeit};
    checks++;
    if (got !== 16'h0) begin
      failures++;
      $display("FAIL reset_b got=%h exp=%h", got, 16'h0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Human 0 and CPU 1 alternate; each legal move leaves a one-cycle CHECK gap.
  task automatic test_alternate();
    logic [7:0] got, exp;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    got = {if_a.play_en, if_a.active_player, if_a.turn_count};
    exp = {2'b01, 1'b0, 4'd0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL alt_start got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < 3; i++) begin
      if (i % 2 == 0) if_a.player_move = 1'b1;
      else            if_a.cpu_move    = 1'b1;
      tick();
      if_a.player_move = 1'b0;
      if_a.cpu_move    = 1'b0;
      got = {if_a.play_en, if_a.turn_count};
      exp = {2'b00, 4'(i)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL alt_check%0d got=%h exp=%h", i, got, exp);
      end
      tick();
      got = {if_a.play_en, if_a.turn_count};
      exp = {((i % 2 == 0) ? 2'b10 : 2'b01), 4'(i + 1)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL alt_grant%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  // Strobes of the wrong kind for the active player do nothing.
  task automatic test_wrong_strobe();
    logic [7:0] got, exp;
    if_a.player_move = 1'b1;
    tick();
    if_a.player_move = 1'b0;
    got = {if_a.play_en, if_a.active_player, if_a.turn_count};
    exp = {2'b10, 1'b1, 4'd3};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL human_on_cpu got=%h exp=%h", got, exp);
    end
    if_a.cpu_move = 1'b1;
    tick();
    if_a.cpu_move = 1'b0;
    tick();
    if_a.cpu_move = 1'b1;
    tick();
    if_a.cpu_move = 1'b0;
    got = {if_a.play_en, if_a.active_player, if_a.turn_count};
    exp = {2'b01, 1'b0, 4'd4};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cpu_on_human got=%h exp=%h", got, exp);
    end
  endtask

  // Third illegal attempt forfeits the turn without counting a move.
  task automatic test_illegal();
    logic [7:0] got, exp;
    if_a.player_move  = 1'b1;
    if_a.illegal_move = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {if_a.forfeit, if_a.play_en, if_a.active_player, if_a.turn_count};
      exp = (i < 2) ? {1'b0, 2'b01, 1'b0, 4'd4} : {1'b1, 2'b10, 1'b1, 4'd4};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL illegal%0d got=%h exp=%h", i, got, exp);
      end
    end
    if_a.player_move  = 1'b0;
    if_a.illegal_move = 1'b0;
    tick();
    got = {if_a.forfeit, if_a.timeout, if_a.play_en};
    exp = {1'b0, 1'b0, 2'b10};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL illegal_pulse_end got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_abort();
    logic [7:0] got;
    if_a.abort = 1'b1;
    tick();
    if_a.abort = 1'b0;
    got = {if_a.play_en, if_a.game_done, if_a.winner_valid, if_a.turn_count};
    checks++;
    if (got !== 8'h0) begin
      failures++;
      $display("FAIL abort got=%h exp=%h", got, 8'h0);
    end
    tick();
    got = {6'd0, if_a.play_en};
    checks++;
    if (got !== 8'h0) begin
      failures++;
      $display("FAIL abort_idle got=%h exp=%h", got, 8'h0);
    end
  endtask

  // Nine legal moves fill the board; no_space without win ends in a draw.
  task automatic test_draw();
    logic [7:0] got, exp;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) if_a.player_move = 1'b1;
      else            if_a.cpu_move    = 1'b1;
      tick();
      if_a.player_move = 1'b0;
      if_a.cpu_move    = 1'b0;
      if_a.no_space    = (i == 8);
      tick();
      if_a.no_space = 1'b0;
      if (i < 8) begin
        got = {if_a.play_en, if_a.game_done, if_a.turn_count};
        exp = {((i % 2 == 0) ? 2'b10 : 2'b01), 1'b0, 4'(i + 1)};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL draw_move%0d got=%h exp=%h", i, got, exp);
        end
      end
    end
    got = {if_a.game_done, if_a.winner_valid, if_a.play_en, if_a.turn_count};
    exp = {1'b1, 1'b0, 2'b00, 4'd9};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL draw_end got=%h exp=%h", got, exp);
    end
    tick();
    got = {7'd0, if_a.game_done};
    checks++;
    if (got !== 8'd1) begin
      failures++;
      $display("FAIL draw_hold got=%h exp=%h", got, 8'd1);
    end
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    got = {if_a.game_done, if_a.play_en, if_a.active_player, if_a.turn_count};
    exp = {1'b0, 2'b01, 1'b0, 4'd0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL draw_restart got=%h exp=%h", got, exp);
    end
  endtask

  // Three players; win reported in the CHECK after the fifth move (player 1).
  task automatic test_win();
    logic [15:0] got, exp;
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    got = {13'd0, if_b.play_en};
    checks++;
    if (got !== 16'd1) begin
      failures++;
      $display("FAIL win_start got=%h exp=%h", got, 16'd1);
    end
    for (int i = 0; i < 5; i++) begin
      if_b.player_move = 1'b1;
      tick();
      if_b.player_move = 1'b0;
      if_b.win         = (i == 4);
      tick();
      if_b.win = 1'b0;
    end
    got = {if_b.game_done, if_b.winner_valid, if_b.winner_id, if_b.turn_count, if_b.play_en};
    exp = {1'b1, 1'b1, 2'd1, 4'd5, 3'b000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL win_end got=%h exp=%h", got, exp);
    end
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    got = {if_b.play_en, if_b.turn_count, if_b.game_done, if_b.winner_valid, if_b.winner_id};
    exp = {3'b001, 4'd0, 1'b0, 1'b0, 2'd0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL win_restart got=%h exp=%h", got, exp);
    end
  endtask

  // Four idle TURN cycles expire the turn; a strobe on the expiry cycle wins.
  task automatic test_timeout();
    logic [15:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {if_b.timeout, if_b.forfeit, if_b.play_en};
      exp = {1'b0, 1'b0, 3'b001};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL to_wait%0d got=%h exp=%h", i, got, exp);
      end
    end
    tick();
    got = {if_b.timeout, if_b.forfeit, if_b.play_en, if_b.active_player, if_b.turn_count};
    exp = {1'b1, 1'b1, 3'b010, 2'd1, 4'd0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL to_expire got=%h exp=%h", got, exp);
    end
    tick();
    got = {if_b.timeout, if_b.forfeit, if_b.play_en};
    exp = {1'b0, 1'b0, 3'b010};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL to_pulse_end got=%h exp=%h", got, exp);
    end
    tick();
    tick();
    got = {if_b.timeout, if_b.forfeit, if_b.play_en};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL to_last_cycle got=%h exp=%h", got, exp);
    end
    if_b.player_move = 1'b1;
    tick();
    if_b.player_move = 1'b0;
    got = {if_b.timeout, if_b.forfeit, if_b.play_en};
    exp = {1'b0, 1'b0, 3'b000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL to_strobe_wins got=%h exp=%h", got, exp);
    end
    tick();
    got = {if_b.play_en, if_b.active_player, if_b.turn_count};
    exp = {3'b100, 2'd2, 4'd1};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL to_next_grant got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_reset_in_check();
    logic [15:0] got;
    if_b.player_move = 1'b1;
    tick();
    if_b.player_move = 1'b0;
    got = {13'd0, if_b.play_en};
    checks++;
    if (got !== 16'd0) begin
      failures++;
      $display("FAIL rchk_in_check got=%h exp=%h", got, 16'd0);
    end
    rst_n = 1'b0;
    tick();
    got = {if_b.play_en, if_b.active_player, if_b.turn_count, if_b.game_done,
           if_b.winner_valid, if_b.winner_id, if_b.timeout, if_b.forfeit};
    checks++;
    if (got !== 16'd0) begin
      failures++;
      $display("FAIL rchk_reset got=%h exp=%h", got, 16'd0);
    end
    rst_n = 1'b1;
    tick();
    got = {13'd0, if_b.play_en};
    checks++;
    if (got !== 16'd0) begin
      failures++;
      $display("FAIL rchk_idle got=%h exp=%h", got, 16'd0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    {if_a.start, if_a.abort, if_a.player_move, if_a.cpu_move,
     if_a.illegal_move, if_a.win, if_a.no_space} = '0;
    {if_b.start, if_b.abort, if_b.player_move, if_b.cpu_move,
     if_b.illegal_move, if_b.win, if_b.no_space} = '0;
    test_reset();
    test_alternate();
    test_wrong_strobe();
    test_illegal();
    test_abort();
    test_draw();
    test_win();
    test_timeout();
    test_reset_in_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
